// File: rtl/ht_res_rr_arb_if.sv
// Result-merge bus: DIR_CNT valid/ready producer streams in, one tagged stream out.
// The slave modport is the arbiter's view; master is the producer/consumer side.
interface ht_res_rr_arb_if #(
   parameter int DIR_CNT  = 3,
   parameter int RESULT_W = 64
);
   localparam int SRC_W = (DIR_CNT > 1) ? $clog2(DIR_CNT) : 1;

   logic [DIR_CNT*RESULT_W-1:0] in_result_i;
   logic [DIR_CNT-1:0]          in_valid_i;
   logic [DIR_CNT-1:0]          in_ready_o;
   logic [RESULT_W-1:0]         out_result_o;
   logic [SRC_W-1:0]            out_src_o;
   logic                        out_valid_o;
   logic                        out_ready_i;

   modport slave (
      input  in_result_i, in_valid_i, out_ready_i,
      output in_ready_o, out_result_o, out_src_o, out_valid_o
   );

   modport master (
      output in_result_i, in_valid_i, out_ready_i,
      input  in_ready_o, out_result_o, out_src_o, out_valid_o
   );
endinterface

// File: rtl/ht_res_rr_arb.sv
// Round-robin / fixed-priority merge of DIR_CNT result streams into one,
// through a 2-entry registered skid buffer, with a saturating contention counter.
module ht_res_rr_arb #(
   parameter int DIR_CNT  = 3,
   parameter int RESULT_W = 64,
   parameter int ARB_MODE = 1,
   parameter int STAT_W   = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   ht_res_rr_arb_if.slave    bus,
   output logic [STAT_W-1:0] stat_collide_o,
   input  logic              stat_clr_i
);
   localparam int SRC_W = (DIR_CNT > 1) ? $clog2(DIR_CNT) : 1;

   logic [1:0]          r_cnt;
   logic [SRC_W-1:0]    r_ptr;
   logic [SRC_W-1:0]    r_head_src;
   logic [SRC_W-1:0]    r_skid_src;
   logic [RESULT_W-1:0] r_head_dat;
   logic [RESULT_W-1:0] r_skid_dat;
   logic [STAT_W-1:0]   r_stat;

   logic                w_accept;
   logic                w_any;
   logic                w_push;
   logic                w_pop;
   logic                w_multi;
   logic [SRC_W-1:0]    w_gidx;
   logic [DIR_CNT-1:0]  w_grant;
   logic [RESULT_W-1:0] w_gdat;
   int unsigned         w_idx;

   // Rotating search starting at r_ptr; first valid channel wins.
   always_comb begin
      w_any  = 1'b0;
      w_gidx = '0;
      w_idx  = 0;
      for (int unsigned i = 0; i < DIR_CNT; i++) begin
         w_idx = 32'(r_ptr) + i;
         if (w_idx >= DIR_CNT) w_idx = w_idx - DIR_CNT;
         if (!w_any && bus.in_valid_i[SRC_W'(w_idx)]) begin
            w_any  = 1'b1;
            w_gidx = SRC_W'(w_idx);
         end
      end
   end

   always_comb begin
      w_grant = '0;
      if (w_any) w_grant[w_gidx] = 1'b1;
   end

   assign w_accept        = (r_cnt != 2'd2);
   assign w_push          = w_accept & w_any;
   assign w_pop           = bus.out_valid_o & bus.out_ready_i;
   assign w_gdat          = bus.in_result_i[w_gidx*RESULT_W +: RESULT_W];
   assign w_multi         = ($countones(bus.in_valid_i) >= 2);

   assign bus.in_ready_o   = w_accept ? w_grant : '0;
   assign bus.out_valid_o  = (r_cnt != 2'd0);
   assign bus.out_result_o = r_head_dat;
   assign bus.out_src_o    = r_head_src;
   assign stat_collide_o   = r_stat;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_ptr <= '0;
      end else if (ARB_MODE == 1 && w_push) begin
         r_ptr <= (w_gidx == SRC_W'(DIR_CNT - 1)) ? '0 : w_gidx + 1'b1;
      end
   end

   // Head entry is the output register; skid holds the second word.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cnt      <= '0;
         r_head_dat <= '0;
         r_head_src <= '0;
         r_skid_dat <= '0;
         r_skid_src <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_cnt == 2'd0) begin
                  r_head_dat <= w_gdat;
                  r_head_src <= w_gidx;
               end else begin
                  r_skid_dat <= w_gdat;
                  r_skid_src <= w_gidx;
               end
               r_cnt <= r_cnt + 2'd1;
            end
            2'b01: begin
               if (r_cnt == 2'd2) begin
                  r_head_dat <= r_skid_dat;
                  r_head_src <= r_skid_src;
               end
               r_cnt <= r_cnt - 2'd1;
            end
            // push needs count<2 and pop needs count>0, so count is 1 here
            2'b11: begin
               r_head_dat <= w_gdat;
               r_head_src <= w_gidx;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_stat <= '0;
      end else if (stat_clr_i) begin
         r_stat <= '0;
      end else if (w_multi && r_stat != '1) begin
         r_stat <= r_stat + 1'b1;
      end
   end
endmodule

// File: tb/tb_ht_res_rr_arb.sv
// Drives a round-robin instance (STAT_W=4) and a fixed-priority instance side by side
// and compares both against a transaction-level model of arbitration, buffer and counter.
module tb_ht_res_rr_arb;
   localparam int N = 3;
   localparam int W = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]   vld  [2];
   logic [N*W-1:0] dat  [2];
   logic           ordy [2];
   logic           clr  [2];
   logic [3:0]     stat_rr;
   logic [15:0]    stat_fp;

   ht_res_rr_arb_if #(.DIR_CNT(N), .RESULT_W(W)) bus_rr ();
   ht_res_rr_arb_if #(.DIR_CNT(N), .RESULT_W(W)) bus_fp ();

   assign bus_rr.in_valid_i  = vld[0];
   assign bus_rr.in_result_i = dat[0];
   assign bus_rr.out_ready_i = ordy[0];
   assign bus_fp.in_valid_i  = vld[1];
   assign bus_fp.in_result_i = dat[1];
   assign bus_fp.out_ready_i = ordy[1];

   ht_res_rr_arb #(.DIR_CNT(N), .RESULT_W(W), .ARB_MODE(1), .STAT_W(4)) u_rr (
      .clk_i(clk), .rst_n_i(rst_n), .bus(bus_rr),
      .stat_collide_o(stat_rr), .stat_clr_i(clr[0])
   );
   ht_res_rr_arb #(.DIR_CNT(N), .RESULT_W(W), .ARB_MODE(0), .STAT_W(16)) u_fp (
      .clk_i(clk), .rst_n_i(rst_n), .bus(bus_fp),
      .stat_collide_o(stat_fp), .stat_clr_i(clr[1])
   );

   // Reference model: per instance an ordered list of {src,data}, pointer, counter.
   int          checks = 0;
   int          failures = 0;
   int          mcnt [2];
   logic [W-1:0] mq_d [2][2];
   int          mq_s [2][2];
   int          mptr;
   int          mstat [2];
   int          smax [2] = '{15, 65535};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int arb(input int k);
      int p;
      p = (k == 0) ? mptr : 0;
      for (int i = 0; i < N; i++)
         if (vld[k][(p + i) % N]) return (p + i) % N;
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mcnt[k]  = 0;
         mstat[k] = 0;
         vld[k]   = '0;
      end
      mptr = 0;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_rr_valid"}, 64'(bus_rr.out_valid_o), 64'd0);
      chk({tag, "_fp_valid"}, 64'(bus_fp.out_valid_o), 64'd0);
      chk({tag, "_rr_result"}, bus_rr.out_result_o, 64'd0);
      chk({tag, "_rr_src"}, 64'(bus_rr.out_src_o), 64'd0);
      chk({tag, "_fp_src"}, 64'(bus_fp.out_src_o), 64'd0);
      chk({tag, "_rr_stat"}, 64'(stat_rr), 64'd0);
      chk({tag, "_fp_stat"}, 64'(stat_fp), 64'd0);
   endtask

   task automatic put(input int k, input int g, input logic [W-1:0] d);
      vld[k][g] = 1'b1;
      dat[k][g*W +: W] = d;
   endtask

   task automatic refill(input int k, input logic [N-1:0] mask);
      for (int g = 0; g < N; g++)
         if (mask[g] && !vld[k][g]) put(k, g, {$urandom, $urandom});
   endtask

   // One clock: compare outputs against the model, then advance the model past the edge.
   task automatic step();
      int g [2];
      bit acc [2];
      bit pop [2];
      bit coll;
      #1;
      for (int k = 0; k < 2; k++) begin
         g[k]   = arb(k);
         acc[k] = (mcnt[k] < 2) && (g[k] >= 0);
         pop[k] = (mcnt[k] > 0) && ordy[k];
         chk($sformatf("in_ready%0d", k),
             64'((k == 0) ? bus_rr.in_ready_o : bus_fp.in_ready_o),
             acc[k] ? (64'd1 << g[k]) : 64'd0);
         chk($sformatf("out_valid%0d", k),
             64'((k == 0) ? bus_rr.out_valid_o : bus_fp.out_valid_o), 64'(mcnt[k] > 0));
         if (mcnt[k] > 0) begin
            chk($sformatf("out_result%0d", k),
                (k == 0) ? bus_rr.out_result_o : bus_fp.out_result_o, mq_d[k][0]);
            chk($sformatf("out_src%0d", k),
                64'((k == 0) ? bus_rr.out_src_o : bus_fp.out_src_o), 64'(mq_s[k][0]));
         end
         chk($sformatf("stat%0d", k), (k == 0) ? 64'(stat_rr) : 64'(stat_fp), 64'(mstat[k]));
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         coll = ($countones(vld[k]) >= 2);
         if (clr[k]) mstat[k] = 0;
         else if (coll && mstat[k] < smax[k]) mstat[k]++;
         if (pop[k]) begin
            mq_d[k][0] = mq_d[k][1];
            mq_s[k][0] = mq_s[k][1];
            mcnt[k]--;
         end
         if (acc[k]) begin
            mq_d[k][mcnt[k]] = dat[k][g[k]*W +: W];
            mq_s[k][mcnt[k]] = g[k];
            mcnt[k]++;
            vld[k][g[k]] = 1'b0;
            if (k == 0) mptr = (g[k] + 1) % N;
         end
      end
   endtask

   task automatic set_ready(input logic r);
      ordy[0] = r;
      ordy[1] = r;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         dat[k] = '0;
         clr[k] = 1'b0;
      end
      set_ready(1'b1);
      model_reset();
      #1;
      check_reset("por");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single channel back-to-back
      put(0, 1, 64'hA); put(1, 1, 64'hA);
      step();
      put(0, 1, 64'hB); put(1, 1, 64'hB);
      step();
      put(0, 1, 64'hC); put(1, 1, 64'hC);
      step();
      step();
      step();

      // All channels valid: rotation on rr instance, ch0 lock on fp instance
      for (int c = 0; c < 6; c++) begin
         refill(0, 3'b111);
         refill(1, 3'b111);
         step();
      end
      vld[0] = '0; vld[1] = '0;
      step(); step();

      // Fixed priority with ch0 and ch2 valid
      for (int c = 0; c < 6; c++) begin
         refill(0, 3'b101);
         refill(1, 3'b101);
         step();
      end
      vld[0] = '0; vld[1] = '0;
      step(); step();

      // Backpressure: third word must wait
      set_ready(1'b0);
      put(0, 0, 64'h1); put(1, 0, 64'h1);
      step();
      put(0, 0, 64'h2); put(1, 0, 64'h2);
      step();
      put(0, 0, 64'h3); put(1, 0, 64'h3);
      step(); step();
      set_ready(1'b1);
      for (int c = 0; c < 5; c++) step();

      // Reset with a full buffer
      set_ready(1'b0);
      put(0, 2, 64'h11); put(1, 2, 64'h11);
      step();
      put(0, 1, 64'h22); put(1, 1, 64'h22);
      step();
      rst_n = 1'b0;
      #1;
      check_reset("midrst");
      model_reset();
      #1;
      rst_n = 1'b1;
      set_ready(1'b1);
      for (int c = 0; c < 4; c++) begin
         refill(0, 3'b111);
         refill(1, 3'b111);
         step();
      end
      vld[0] = '0; vld[1] = '0;
      step(); step();

      // Saturation of the 4-bit counter, then clear during a collision
      for (int c = 0; c < 20; c++) begin
         refill(0, 3'b011);
         refill(1, 3'b011);
         step();
      end
      refill(0, 3'b011); refill(1, 3'b011);
      clr[0] = 1'b1; clr[1] = 1'b1;
      step();
      clr[0] = 1'b0; clr[1] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         refill(0, 3'b011);
         refill(1, 3'b011);
         step();
      end

      // Random traffic with random backpressure and occasional clears
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 2; k++) begin
            for (int g = 0; g < N; g++)
               if (!vld[k][g] && $urandom_range(0, 1) == 1) put(k, g, {$urandom, $urandom});
            ordy[k] = ($urandom_range(0, 3) != 0);
            clr[k]  = ($urandom_range(0, 31) == 0);
         end
         step();
      end

      // Drain: every accepted word must come out
      for (int k = 0; k < 2; k++) begin
         clr[k] = 1'b0;
      end
      for (int c = 0; c < 12; c++) step();
      vld[0] = '0; vld[1] = '0;
      set_ready(1'b1);
      for (int c = 0; c < 4; c++) step();
      chk("drained_rr", 64'(bus_rr.out_valid_o), 64'd0);
      chk("drained_fp", 64'(bus_fp.out_valid_o), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ht_res_rr_arb.md
Name: ht_res_rr_arb

Overview:
Parametrised successor to the hash-table result multiplexer. It merges DIR_CNT valid/ready result streams into one output stream. Arbitration is true round-robin or fixed-priority, so simultaneous valids are arbitrated rather than assumed exclusive. The output passes through a 2-entry registered skid buffer, so out_ready has no combinational path to any in_ready. The block sits between the per-direction hash-table engines and the single result consumer, and tags each output word with its source channel and counts contention.

Parameters:
DIR_CNT, 3, number of input channels (>=1)
RESULT_W, 64, width of one result word
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
STAT_W, 16, width of saturating contention counter
SRC_W (localparam), max(1,$clog2(DIR_CNT)), width of source index

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
in_result_i  in  DIR_CNT*RESULT_W  input results; channel g in bits [g*RESULT_W +: RESULT_W]
in_valid_i  in  DIR_CNT  per-channel valid
in_ready_o  out  DIR_CNT  per-channel ready
out_result_o  out  RESULT_W  merged result
out_src_o  out  SRC_W  index of the channel that produced out_result_o
out_valid_o  out  1  output valid
out_ready_i  in  1  output ready
stat_collide_o  out  STAT_W  cycles with two or more in_valid_i bits set, saturating
stat_clr_i  in  1  synchronous clear of stat_collide_o

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-low (rst_n_i), as already decided.
- Reset values: buffer count = 0, out_valid_o = 0, out_result_o = 0, out_src_o = 0, rr pointer = 0, stat_collide_o = 0.
- Reset mid-operation discards all buffered entries with no output.
- Handshake: a transfer occurs on any port in a cycle where valid and ready are both high.
  - Inputs must hold data and valid until accepted.
  - The block holds out_result_o, out_src_o and out_valid_o stable while out_valid_o=1 and out_ready_i=0.
- accept = (count < 2). count is 2 bits (0..2).
- Grant (combinational):
  - Among in_valid_i bits, choose the first set bit searching ptr, ptr+1, ..., DIR_CNT-1, 0, ..., ptr-1.
  - in_ready_o[g] = accept & grant[g].
  - At most one in_ready_o bit is high in any cycle.
  - in_ready_o is 0 for every channel whose valid is low.
  - in_ready_o may depend on in_valid_i.
- Pointer update:
  - ARB_MODE=1: on an input transfer from channel g, ptr <= (g+1) mod DIR_CNT. With no transfer, ptr holds.
  - ARB_MODE=0: ptr is constant 0.
- Buffer: 2-entry FIFO of {src, result}.
  - Push on input transfer; pop on output transfer.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - out_valid_o = (count != 0). The output is the head entry, driven from registers.
- Latency: input accepted in cycle N → visible on output in cycle N+1 (buffer empty case).
- Throughput: 1 word per cycle sustained when out_ready_i=1.
- Full buffer (count=2) with out_ready_i=0: all in_ready_o = 0.
- Full buffer with out_ready_i=1: pop occurs, but no push in that cycle, since accept uses the registered count. One bubble cycle is accepted behaviour after a stall.
- DIR_CNT=1: grant = in_valid_i[0], out_src_o = 0, ptr unused.
- Contention statistics:
  - Each cycle with popcount(in_valid_i) >= 2 increments stat_collide_o, saturating at all ones.
  - stat_clr_i=1 loads 0 and takes priority over increment.
- Ordering: results from one channel leave in acceptance order. No ordering is guaranteed across channels.
- No data word is dropped or duplicated under any combination of valid and ready.

Test Plan:
1. Single channel, back-to-back: DIR_CNT=3, ch1 sends 0xA, 0xB, 0xC with out_ready_i=1 → outputs 0xA, 0xB, 0xC on consecutive cycles starting 1 cycle after the first accept, out_src_o=1 each, stat stays 0.
2. Round-robin fairness: ARB_MODE=1, all 3 channels continuously valid, out_ready_i=1 → grant order 0, 1, 2, 0, 1, 2…; stat_collide_o increments every cycle.
3. Fixed priority: ARB_MODE=0, ch0 and ch2 continuously valid for 6 cycles → only ch0 accepted, ch2's in_ready_o stays 0, stat_collide_o = 6.
4. Backpressure: out_ready_i=0, ch0 offers 0x1, 0x2, 0x3 → 0x1 and 0x2 accepted, count=2, in_ready_o=0 for 0x3. Releasing out_ready_i → outputs 0x1, 0x2, 0x3 in order, no loss, no duplicates.
5. Reset mid-stream: async assert rst_n_i with count=2 → out_valid_o=0 immediately, ptr=0. After release, the first new word appears normally.
6. Stat saturation and clear: STAT_W=4, 20 collision cycles → stat_collide_o=15. stat_clr_i pulsed during a collision cycle → value 0 that cycle, increments thereafter.
